// File: rtl/led_display_arbiter.sv
// led_display_arbiter: round-robin owner selection for the shared 4-digit LED
// value (lednum). Each grant snapshots the winner's value and holds it for
// HOLD_CYCLES cycles, or for less if the owner drops its request early.
module led_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter logic [15:0] IDLE_VALUE  = 16'h0000,
  parameter int unsigned CNT_W       = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  output logic [15:0] lednum,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic        busy
);

  typedef enum logic {IDLE, SHOW} state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        last;
  logic [1:0]        cand;
  logic [1:0]        win;
  logic              win_vld;
  logic [15:0]       win_val;

  // Round-robin search starting after the last winner, which is also the
  // current owner while in SHOW.
  always_comb begin
    cand    = '0;
    win     = last;
    win_vld = 1'b0;
    for (int unsigned i = 1; i <= 3; i++) begin
      cand = 2'((32'(last) + i) % 3);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Value of the winning source, snapshotted into lednum on a grant.
  always_comb begin
    case (win)
      2'd0:    win_val = val0;
      2'd1:    win_val = val1;
      default: win_val = val2;
    endcase
  end

  // Grant/dwell state machine with registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      done   <= '0;
      cnt    <= '0;
      last   <= 2'd2;
      lednum <= IDLE_VALUE;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant  <= 3'b001 << win;
            lednum <= win_val;
            cnt    <= HOLD_LOAD;
            last   <= win;
            state  <= SHOW;
          end
        end
        SHOW: begin
          if (cnt == '0) begin
            // Terminal count wins over a falling owner request.
            done <= grant;
            if (win_vld) begin
              grant  <= 3'b001 << win;
              lednum <= win_val;
              cnt    <= HOLD_LOAD;
              last   <= win;
            end else begin
              grant <= '0;
              state <= IDLE;
            end
          end else if (!req[last]) begin
            grant <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = |grant;

endmodule

// File: tb/tb_led_display_arbiter.sv
// tb_led_display_arbiter: directed stimulus, per-cycle comparison against a
// behavioural model of the arbiter, plus literal checkpoints.
module tb_led_display_arbiter;

  localparam int unsigned H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [15:0] val0 = '0;
  logic [15:0] val1 = '0;
  logic [15:0] val2 = '0;
  logic [15:0] lednum;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  bit started = 0;

  led_display_arbiter #(
    .HOLD_CYCLES(H),
    .IDLE_VALUE(16'h0000),
    .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .val0(val0), .val1(val1), .val2(val2),
    .lednum(lednum), .grant(grant), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: owner index (-1 = nobody), cycles of display left
  // including the current one, round-robin memory and the shown value.
  int          m_owner = -1;
  int          m_left  = 0;
  int          m_last  = 2;
  logic [15:0] m_shown = '0;
  logic [2:0]  m_done  = '0;

  function automatic logic [15:0] value_of(int s);
    if (s == 0) return val0;
    if (s == 1) return val1;
    return val2;
  endfunction

  function automatic int pick(int after);
    for (int k = 1; k <= 3; k++) begin
      if (req[(after + k) % 3]) return (after + k) % 3;
    end
    return -1;
  endfunction

  task automatic give(int s);
    m_owner = s;
    m_last  = s;
    m_left  = H;
    m_shown = value_of(s);
  endtask

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_owner = -1; m_left = 0; m_last = 2; m_shown = 16'h0000; m_done = '0;
    end else begin
      m_done = '0;
      if (m_owner < 0) begin
        if (req != 0) give(pick(m_last));
      end else if (m_left == 1) begin
        m_done[m_owner] = 1'b1;
        if (req != 0) give(pick(m_owner));
        else m_owner = -1;
      end else if (!req[m_owner]) begin
        m_owner = -1;
      end else begin
        m_left = m_left - 1;
      end
    end
  end

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("model_lednum", lednum, m_shown);
      check("model_grant", 16'(grant), (m_owner < 0) ? 16'h0 : 16'(1 << m_owner));
      check("model_done", 16'(done), 16'(m_done));
      check("model_busy", 16'(busy), (m_owner < 0) ? 16'h0 : 16'h1);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("rst_lednum", lednum, 16'h0000);
    check("rst_grant", 16'(grant), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);

    // Single source, full dwell, completion as req falls
    val0 = 16'h1234; req = 3'b001;
    cyc(1);
    check("s0_grant", 16'(grant), 16'h1);
    check("s0_lednum", lednum, 16'h1234);
    cyc(3);
    check("s0_grant_last", 16'(grant), 16'h1);
    req = 3'b000;
    cyc(1);
    check("s0_done", 16'(done), 16'h1);
    check("s0_released", 16'(grant), 16'h0);
    check("s0_hold_val", lednum, 16'h1234);
    cyc(2);

    // All three requesting: back-to-back rotation from a fresh pointer
    rst = 1'b1; cyc(1); rst = 1'b0;
    val0 = 16'h1111; val1 = 16'h2222; val2 = 16'h3333; req = 3'b111;
    cyc(1);
    check("rr_first", lednum, 16'h1111);
    cyc(4);
    check("rr_second_grant", 16'(grant), 16'h2);
    check("rr_second_done", 16'(done), 16'h1);
    check("rr_second_val", lednum, 16'h2222);
    cyc(4);
    check("rr_third_val", lednum, 16'h3333);
    cyc(4);
    check("rr_wrap_grant", 16'(grant), 16'h1);
    check("rr_wrap_done", 16'(done), 16'h4);
    cyc(3);
    req = 3'b000;
    cyc(3);

    // Snapshot: value change during the dwell is not shown
    val1 = 16'h00AB; req = 3'b010;
    cyc(1);
    check("snap_grant", 16'(grant), 16'h2);
    cyc(2);
    val1 = 16'h00CD;
    cyc(1);
    check("snap_frozen", lednum, 16'h00AB);
    cyc(1);
    check("snap_regrant_val", lednum, 16'h00CD);
    check("snap_regrant_done", 16'(done), 16'h2);
    req = 3'b000;
    cyc(6);

    // Abort: owner drops request mid-dwell
    val2 = 16'h3333; req = 3'b100;
    cyc(2);
    req = 3'b000;
    cyc(1);
    check("abort_grant", 16'(grant), 16'h0);
    check("abort_done", 16'(done), 16'h0);
    check("abort_lednum", lednum, 16'h3333);
    req = 3'b100;
    cyc(1);
    check("abort_regrant", 16'(grant), 16'h4);

    // Reset mid-dwell, then pointer restarts at source 0
    cyc(1);
    rst = 1'b1;
    cyc(1);
    check("mid_rst_grant", 16'(grant), 16'h0);
    check("mid_rst_lednum", lednum, 16'h0000);
    rst = 1'b0; req = 3'b110;
    cyc(1);
    check("post_rst_grant", 16'(grant), 16'h2);
    check("post_rst_lednum", lednum, 16'h00CD);
    req = 3'b000;
    cyc(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_display_arbiter.md
Name: led_display_arbiter

Overview:
Shares one 4-digit LED display datapath (the 16-bit lednum value feeding the multiplexed digit driver) between three requesting sources. Each source raises a request with its 16-bit BCD/hex value. The arbiter grants the display round-robin and holds the granted value stable for a programmable dwell time. It sits between the application logic and the Led_Display driver, and drives the driver's lednum input.

Parameters:
HOLD_CYCLES, 1000, dwell time per grant in clk cycles; must be >= 1
IDLE_VALUE, 16'h0000, lednum value after reset
CNT_W, 10, hold counter width; must satisfy 2^CNT_W >= HOLD_CYCLES

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset; synchronous, active-high
req  input  3  request per source; level, held high while the source wants the display
val0  input  16  display value of source 0
val1  input  16  display value of source 1
val2  input  16  display value of source 2
lednum  output  16  value to the display driver; registered
grant  output  3  one-hot current owner; 000 when idle; registered
done  output  3  one-cycle pulse on the owner's bit when its dwell completes normally
busy  output  1  high while any grant is active (equals OR of grant)

Behaviour:
- Reset (rst sampled high at a rising edge): lednum=IDLE_VALUE, grant=000, done=000, busy=0, hold counter=0, state=IDLE, rr pointer last=2 (so source 0 has first priority). Reset overrides everything, including a grant in progress.
- States: IDLE, SHOW.
- Round-robin order: search last+1, last+2, last+3 (mod 3). The first source with req high wins. On every grant, last is set to the winner.
- IDLE: at an edge where any req bit is high:
  - grant becomes one-hot for the winner.
  - lednum is set to a snapshot of that source's val.
  - counter is loaded with HOLD_CYCLES-1, and the state goes to SHOW.
  - Latency is one edge: sampled req produces grant and lednum visible in the following cycle.
- SHOW, counter>0, req[owner] high: counter decrements by 1 per cycle. lednum is frozen; changes on val inputs are ignored.
- SHOW, counter==0 (terminal): done[owner]=1 for the next cycle only. Then:
  - If any req is high, re-arbitrate on the same edge, starting after the current owner. The new grant and snapshot apply immediately, with no idle gap. The same source may be re-granted if it is the only requester.
  - Otherwise grant=000 and the state goes to IDLE.
- Grant duration: with req held, grant stays high for exactly HOLD_CYCLES cycles.
- Abort: req[owner] sampled low while SHOW with counter>0:
  - At that edge grant goes to 000 and the state goes to IDLE; no done pulse.
  - The next arbitration happens at the following edge; abort and re-grant do not occur on the same edge.
- Terminal count and owner req falling on the same edge: this is a normal completion, so done pulses.
- IDLE lednum: keeps the last displayed value (no blanking); only reset restores IDLE_VALUE.
- HOLD_CYCLES=1: every grant lasts one cycle. With continuous requests the grant rotates every cycle and done pulses every cycle.
- Non-owner req bits may change at any time without effect until the next arbitration.
- done is registered and never has more than one bit set.

Test Plan:
- HOLD_CYCLES=4. Assert rst for 2 cycles, then release → lednum=0000, grant=000, done=000, busy=0.
- req=001, val0=1234 held → one edge later grant=001, lednum=1234, busy=1 for exactly 4 cycles; then done=001 for 1 cycle; with req0 dropped, grant=000 and lednum stays 1234.
- req=111 held, val0=1111, val1=2222, val2=3333 → grant runs 001,010,100,001 with 4 cycles each and no gaps; lednum follows 1111,2222,3333,1111; done pulses 001,010,100 at each switch.
- Grant to source 1 with val1=00AB; change val1 to 00CD after 2 cycles → lednum stays 00AB for the whole dwell; the next grant to source 1 shows 00CD.
- Grant to source 2; drop req2 after 2 cycles → grant=000 at the next edge, done stays 000, lednum holds its value; re-raise req2 → granted after one edge.
- Assert rst mid-dwell → outputs return to reset values at the next edge. Then req=110 → grant=010 (pointer reset to 2, so source 1 precedes 2), lednum=val1.
